// File: rtl/sram_arb_pkg.sv
// Shared types and default constants for the base-SRAM arbiter: FSM states,
// requester indices and the latched command layout.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W       = 20;
    localparam int SRAM_DATA_W       = 32;
    localparam int SRAM_BE_W         = SRAM_DATA_W / 8;
    localparam int DEF_ACCESS_CYCLES = 2;
    localparam int DEF_MAX_BURST     = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_e;

    typedef enum logic {
        PORT_VIDEO = 1'b0,
        PORT_GEN   = 1'b1
    } port_e;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [SRAM_BE_W-1:0]   be;
    } cmd_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Winner selection between the video fetcher and the general port, with a
// saturating starvation counter that eventually lets the general port through.
import sram_arb_pkg::*;

module sram_arb_pick #(
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  req0_i,
    input  logic  req1_i,
    input  logic  sample_en_i,
    output port_e winner_o,
    output logic  valid_o
);

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    logic [3:0] starve_q, starve_d;

    always_comb begin
        winner_o = PORT_VIDEO;
        valid_o  = req0_i | req1_i;
        if (req1_i && (!req0_i || starve_q == BURST_LIMIT)) begin
            winner_o = PORT_GEN;
        end
    end

    // Count video grants taken while the general port was waiting.
    always_comb begin
        starve_d = starve_q;
        if (sample_en_i) begin
            if (!req1_i || winner_o == PORT_GEN) begin
                starve_d = '0;
            end else if (starve_q != BURST_LIMIT) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and access sequencer for the asynchronous base SRAM; the
// DQ tristate itself lives at the top level.
import sram_arb_pkg::*;

module sram_arbiter #(
    parameter int ADDR_WIDTH    = SRAM_ADDR_W,
    parameter int DATA_WIDTH    = SRAM_DATA_W,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int MAX_BURST     = DEF_MAX_BURST
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    p0_req,
    input  logic                    p0_we,
    input  logic [ADDR_WIDTH-1:0]   p0_addr,
    input  logic [DATA_WIDTH-1:0]   p0_wdata,
    input  logic [DATA_WIDTH/8-1:0] p0_be,
    input  logic                    p1_req,
    input  logic                    p1_we,
    input  logic [ADDR_WIDTH-1:0]   p1_addr,
    input  logic [DATA_WIDTH-1:0]   p1_wdata,
    input  logic [DATA_WIDTH/8-1:0] p1_be,
    output logic                    p0_gnt,
    output logic                    p1_gnt,
    output logic                    p0_done,
    output logic                    p1_done,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH/8-1:0] sram_be_n,
    output logic                    sram_ce_n,
    output logic                    sram_oe_n,
    output logic                    sram_we_n,
    output logic [DATA_WIDTH-1:0]   sram_dq_o,
    output logic                    sram_dq_oe,
    input  logic [DATA_WIDTH-1:0]   sram_dq_i
);

    localparam int         BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [3:0]             acc_q, acc_d;
    port_e                  port_q, port_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BE_WIDTH-1:0]    be_n_q, be_n_d;
    logic [DATA_WIDTH-1:0]  dq_o_q, dq_o_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   ce_n_q, ce_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   we_n_q, we_n_d;
    logic                   gnt0_q, gnt0_d;
    logic                   gnt1_q, gnt1_d;
    logic                   done0_q, done0_d;
    logic                   done1_q, done1_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

    logic                   sample_en;
    port_e                  pick_winner;
    logic                   pick_valid;
    cmd_t                   cmd_sel;

    sram_arb_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .clk         (clk),
        .reset       (reset),
        .req0_i      (p0_req),
        .req1_i      (p1_req),
        .sample_en_i (sample_en),
        .winner_o    (pick_winner),
        .valid_o     (pick_valid)
    );

    always_comb begin
        if (pick_winner == PORT_GEN) begin
            cmd_sel.we    = p1_we;
            cmd_sel.addr  = SRAM_ADDR_W'(p1_addr);
            cmd_sel.wdata = SRAM_DATA_W'(p1_wdata);
            cmd_sel.be    = SRAM_BE_W'(p1_be);
        end else begin
            cmd_sel.we    = p0_we;
            cmd_sel.addr  = SRAM_ADDR_W'(p0_addr);
            cmd_sel.wdata = SRAM_DATA_W'(p0_wdata);
            cmd_sel.be    = SRAM_BE_W'(p0_be);
        end
    end

    // Control strobes default to inactive so only the access states pull them low.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        port_d    = port_q;
        addr_d    = addr_q;
        be_n_d    = be_n_q;
        dq_o_d    = dq_o_q;
        dq_oe_d   = dq_oe_q;
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        rdata_d   = rdata_q;
        sample_en = 1'b0;
        case (state_q)
            IDLE: begin
                sample_en = 1'b1;
                dq_oe_d   = 1'b0;
                if (pick_valid) begin
                    port_d = pick_winner;
                    addr_d = ADDR_WIDTH'(cmd_sel.addr);
                    be_n_d = ~BE_WIDTH'(cmd_sel.be);
                    acc_d  = ACC_LAST;
                    ce_n_d = 1'b0;
                    gnt0_d = (pick_winner == PORT_VIDEO);
                    gnt1_d = (pick_winner == PORT_GEN);
                    if (cmd_sel.we) begin
                        state_d = WRITE;
                        we_n_d  = 1'b0;
                        dq_oe_d = 1'b1;
                        dq_o_d  = DATA_WIDTH'(cmd_sel.wdata);
                    end else begin
                        state_d = READ;
                        oe_n_d  = 1'b0;
                    end
                end
            end
            READ: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                if (acc_q == 4'd0) begin
                    state_d = DONE;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    rdata_d = sram_dq_i;
                    done0_d = (port_q == PORT_VIDEO);
                    done1_d = (port_q == PORT_GEN);
                end else begin
                    acc_d = acc_q - 4'd1;
                end
            end
            WRITE: begin
                ce_n_d = 1'b0;
                we_n_d = 1'b0;
                if (acc_q == 4'd0) begin
                    state_d = DONE;
                    ce_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    done0_d = (port_q == PORT_VIDEO);
                    done1_d = (port_q == PORT_GEN);
                end else begin
                    acc_d = acc_q - 4'd1;
                end
            end
            DONE: begin
                // Write data stays driven through this cycle for hold after we_n rises.
                state_d = IDLE;
                dq_oe_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            port_q  <= PORT_VIDEO;
            addr_q  <= '0;
            be_n_q  <= '1;
            dq_o_q  <= '0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            be_n_q  <= be_n_d;
            dq_o_q  <= dq_o_d;
            dq_oe_q <= dq_oe_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            rdata_q <= rdata_d;
        end
    end

    assign p0_gnt     = gnt0_q;
    assign p1_gnt     = gnt1_q;
    assign p0_done    = done0_q;
    assign p1_done    = done1_q;
    assign rdata      = rdata_q;
    assign sram_addr  = addr_q;
    assign sram_be_n  = be_n_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default instance plus a single-cycle-access
// instance exercised on its general port.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [19:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic [3:0]  p0_be, p1_be;
    logic        p0_gnt, p1_gnt, p0_done, p1_done;
    logic [31:0] rdata;
    logic [19:0] sram_addr;
    logic [3:0]  sram_be_n;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [31:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [31:0] sram_dq_i;

    logic        d1_p1_req;
    logic        d1_p0_gnt, d1_p1_gnt, d1_p0_done, d1_p1_done;
    logic [31:0] d1_rdata;
    logic [19:0] d1_sram_addr;
    logic [3:0]  d1_sram_be_n;
    logic        d1_sram_ce_n, d1_sram_oe_n, d1_sram_we_n;
    logic [31:0] d1_sram_dq_o;
    logic        d1_sram_dq_oe;
    logic [31:0] d1_sram_dq_i;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
        .rdata(rdata), .sram_addr(sram_addr), .sram_be_n(sram_be_n),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i)
    );

    sram_arbiter #(.ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .p0_req(1'b0), .p0_we(1'b0), .p0_addr(20'h0), .p0_wdata(32'h0), .p0_be(4'h0),
        .p1_req(d1_p1_req), .p1_we(1'b0), .p1_addr(20'h00020), .p1_wdata(32'h0), .p1_be(4'hF),
        .p0_gnt(d1_p0_gnt), .p1_gnt(d1_p1_gnt), .p0_done(d1_p0_done), .p1_done(d1_p1_done),
        .rdata(d1_rdata), .sram_addr(d1_sram_addr), .sram_be_n(d1_sram_be_n),
        .sram_ce_n(d1_sram_ce_n), .sram_oe_n(d1_sram_oe_n), .sram_we_n(d1_sram_we_n),
        .sram_dq_o(d1_sram_dq_o), .sram_dq_oe(d1_sram_dq_oe), .sram_dq_i(d1_sram_dq_i)
    );

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_be = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_be = '0;
        sram_dq_i = '0; d1_p1_req = 0; d1_sram_dq_i = '0;
        repeat (2) stepCycle();
        testCount++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
            $display("[TB] FAIL reset_ctrl: got %b expected 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
            failCount++;
        end
        testCount++;
        if ({sram_be_n, sram_addr, sram_dq_o, rdata} !== {4'hF, 20'h0, 32'h0, 32'h0}) begin
            $display("[TB] FAIL reset_data: be_n=%h addr=%h dq_o=%h rdata=%h expected F/0/0/0", sram_be_n, sram_addr, sram_dq_o, rdata);
            failCount++;
        end
        testCount++;
        if ({p0_gnt, p1_gnt, p0_done, p1_done} !== 4'b0000) begin
            $display("[TB] FAIL reset_handshake: got %b expected 0000", {p0_gnt, p1_gnt, p0_done, p1_done});
            failCount++;
        end
        reset = 1'b0;
        stepCycle();
    endtask

    task automatic test_read_p1();
        p1_req = 1; p1_we = 0; p1_addr = 20'h00010; p1_be = 4'hF; sram_dq_i = 32'hDEADBEEF;
        stepCycle();
        p1_req = 0;
        testCount++;
        if ({p1_gnt, p0_gnt, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 6'b100010 || sram_addr !== 20'h00010) begin
            $display("[TB] FAIL read_c1: gnt1/gnt0/ce/oe/we/oe_dq=%b addr=%h expected 100010 addr 00010", {p1_gnt, p0_gnt, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, sram_addr);
            failCount++;
        end
        stepCycle();
        testCount++;
        if ({p1_gnt, sram_ce_n, sram_oe_n, p1_done} !== 4'b0000) begin
            $display("[TB] FAIL read_c2: gnt/ce/oe/done=%b expected 0000", {p1_gnt, sram_ce_n, sram_oe_n, p1_done});
            failCount++;
        end
        stepCycle();
        testCount++;
        if ({p1_done, p0_done, sram_ce_n, sram_oe_n} !== 4'b1011 || rdata !== 32'hDEADBEEF) begin
            $display("[TB] FAIL read_c3: done1/done0/ce/oe=%b rdata=%h expected 1011 DEADBEEF", {p1_done, p0_done, sram_ce_n, sram_oe_n}, rdata);
            failCount++;
        end
        sram_dq_i = 32'h0BADF00D;
        stepCycle();
        testCount++;
        if (p1_done !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            $display("[TB] FAIL read_hold: done=%b rdata=%h expected 0 DEADBEEF", p1_done, rdata);
            failCount++;
        end
    endtask

    task automatic test_write_p0();
        p0_req = 1; p0_we = 1; p0_addr = 20'hFFFFF; p0_wdata = 32'h12345678; p0_be = 4'b0011;
        stepCycle();
        p0_req = 0;
        testCount++;
        if ({p0_gnt, sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe} !== 5'b10011 || sram_be_n !== 4'b1100
            || sram_addr !== 20'hFFFFF || sram_dq_o !== 32'h12345678) begin
            $display("[TB] FAIL write_c1: gnt/ce/we/oe/dqoe=%b be_n=%b addr=%h dq=%h expected 10011 1100 FFFFF 12345678",
                     {p0_gnt, sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}, sram_be_n, sram_addr, sram_dq_o);
            failCount++;
        end
        stepCycle();
        testCount++;
        if ({sram_ce_n, sram_we_n, sram_dq_oe, p0_done} !== 4'b0010) begin
            $display("[TB] FAIL write_c2: ce/we/dqoe/done=%b expected 0010", {sram_ce_n, sram_we_n, sram_dq_oe, p0_done});
            failCount++;
        end
        stepCycle();
        testCount++;
        if ({p0_done, sram_ce_n, sram_we_n, sram_dq_oe} !== 4'b1111 || sram_dq_o !== 32'h12345678) begin
            $display("[TB] FAIL write_done: done/ce/we/dqoe=%b dq=%h expected 1111 12345678", {p0_done, sram_ce_n, sram_we_n, sram_dq_oe}, sram_dq_o);
            failCount++;
        end
        stepCycle();
        testCount++;
        if ({p0_done, sram_dq_oe} !== 2'b00) begin
            $display("[TB] FAIL write_release: done/dqoe=%b expected 00", {p0_done, sram_dq_oe});
            failCount++;
        end
    endtask

    task automatic test_simultaneous();
        p0_req = 1; p0_we = 0; p0_addr = 20'h00100;
        p1_req = 1; p1_we = 0; p1_addr = 20'h00200;
        stepCycle();
        p0_req = 0;
        testCount++;
        if ({p0_gnt, p1_gnt} !== 2'b10 || sram_addr !== 20'h00100) begin
            $display("[TB] FAIL simul_first: gnt0/gnt1=%b addr=%h expected 10 00100", {p0_gnt, p1_gnt}, sram_addr);
            failCount++;
        end
        repeat (2) stepCycle();
        stepCycle();
        testCount++;
        if (p1_gnt !== 1'b0) begin
            $display("[TB] FAIL simul_early: gnt1=%b expected 0", p1_gnt);
            failCount++;
        end
        stepCycle();
        p1_req = 0;
        testCount++;
        if ({p0_gnt, p1_gnt} !== 2'b01 || sram_addr !== 20'h00200) begin
            $display("[TB] FAIL simul_second: gnt0/gnt1=%b addr=%h expected 01 00200", {p0_gnt, p1_gnt}, sram_addr);
            failCount++;
        end
        repeat (4) stepCycle();
    endtask

    task automatic test_starvation();
        int got[10];
        int n = 0;
        int expOrder[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        p0_req = 1; p0_we = 0; p1_req = 1; p1_we = 0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            stepCycle();
            if (p0_gnt === 1'b1 && n < 10) begin got[n] = 0; n++; end
            if (p1_gnt === 1'b1 && n < 10) begin got[n] = 1; n++; end
        end
        p0_req = 0; p1_req = 0;
        testCount++;
        if (n !== 10) begin
            $display("[TB] FAIL starve_count: got %0d grants expected 10", n);
            failCount++;
        end
        for (int i = 0; i < n; i++) begin
            testCount++;
            if (got[i] !== expOrder[i]) begin
                $display("[TB] FAIL starve_order[%0d]: got port %0d expected port %0d", i, got[i], expOrder[i]);
                failCount++;
            end
        end
        repeat (4) stepCycle();
    endtask

    task automatic test_reset_mid_write();
        bit sawDone = 0;
        bit granted = 0;
        p0_req = 1; p0_we = 1; p0_addr = 20'h00333; p0_wdata = 32'h55AA55AA; p0_be = 4'hF;
        stepCycle();
        p0_req = 0;
        p1_req = 1; p1_we = 0; p1_addr = 20'h00044; p1_be = 4'b0101; sram_dq_i = 32'hCAFEF00D;
        #2 reset = 1'b1;
        #1;
        testCount++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, p0_gnt} !== 5'b11100 || sram_be_n !== 4'hF
            || sram_addr !== 20'h0 || sram_dq_o !== 32'h0 || rdata !== 32'h0) begin
            $display("[TB] FAIL midreset_outputs: ctrl=%b be_n=%h addr=%h dq=%h rdata=%h expected 11100 F 0 0 0",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, p0_gnt}, sram_be_n, sram_addr, sram_dq_o, rdata);
            failCount++;
        end
        stepCycle();
        reset = 1'b0;
        for (int c = 0; c < 8 && !granted; c++) begin
            stepCycle();
            if (p0_done === 1'b1) sawDone = 1;
            if (p1_gnt === 1'b1) granted = 1;
        end
        p1_req = 0;
        testCount++;
        if (!granted || sram_be_n !== 4'b1010 || sram_addr !== 20'h00044) begin
            $display("[TB] FAIL midreset_regrant: granted=%0d be_n=%b addr=%h expected 1 1010 00044", granted, sram_be_n, sram_addr);
            failCount++;
        end
        repeat (2) begin
            stepCycle();
            if (p0_done === 1'b1) sawDone = 1;
        end
        testCount++;
        if (p1_done !== 1'b1 || rdata !== 32'hCAFEF00D) begin
            $display("[TB] FAIL midreset_read: done=%b rdata=%h expected 1 CAFEF00D", p1_done, rdata);
            failCount++;
        end
        testCount++;
        if (sawDone) begin
            $display("[TB] FAIL midreset_no_done: got p0_done pulse expected none");
            failCount++;
        end
        repeat (2) stepCycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] expRdata = 32'h0;
        d1_p1_req = 1;
        for (int i = 1; i <= 9; i++) begin
            d1_sram_dq_i = 32'h10000000 + 32'(i);
            stepCycle();
            if (i % 3 == 2) expRdata = 32'h10000000 + 32'(i);
            testCount++;
            if (d1_p1_gnt !== (i % 3 == 1) || d1_p1_done !== (i % 3 == 2) || d1_rdata !== expRdata) begin
                $display("[TB] FAIL b2b_cycle%0d: gnt=%b done=%b rdata=%h expected %b %b %h",
                         i, d1_p1_gnt, d1_p1_done, d1_rdata, (i % 3 == 1), (i % 3 == 2), expRdata);
                failCount++;
            end
        end
        d1_p1_req = 0;
        repeat (3) stepCycle();
    endtask

    initial begin
        test_reset();
        test_read_p1();
        test_write_p0();
        test_simultaneous();
        test_starvation();
        test_reset_mid_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 4 MB base SRAM (32-bit data, 20-bit word address, async SRAM) between two requesters in the clk_100m domain.
  - Port 0 is the video framebuffer fetcher and has priority.
  - Port 1 is the general read/write port, for example a drawing engine.
- Sequences each SRAM access with a state machine: chip-select, output-enable/write-enable timing, data capture, recovery.
- Sits between the requesters and the base_ram_* pins; the tristate buffer stays at the top level.

Parameters:
- ADDR_WIDTH, 20, SRAM word address width.
- DATA_WIDTH, 32, SRAM data width; byte enables are DATA_WIDTH/8.
- ACCESS_CYCLES, 2, cycles that ce_n plus oe_n, or ce_n plus we_n, are held asserted per access; legal range 1..15.
- MAX_BURST, 4, consecutive port-0 grants allowed while port 1 waits; legal range 1..15.

Ports:
- clk  in  1  clock (clk_100m)
- reset  in  1  asynchronous reset, active-high (reset_btn)
- p0_req, p1_req  in  1 each  request; held high until the matching gnt
- p0_we, p1_we  in  1 each  1 = write, 0 = read
- p0_addr, p1_addr  in  ADDR_WIDTH each  word address
- p0_wdata, p1_wdata  in  DATA_WIDTH each  write data
- p0_be, p1_be  in  DATA_WIDTH/8 each  byte enables, active-high
- p0_gnt, p1_gnt  out  1 each  one-cycle pulse: command accepted
- p0_done, p1_done  out  1 each  one-cycle pulse: access complete
- rdata  out  DATA_WIDTH  read data; valid during a done pulse of a read; held until the next read completes
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_be_n  out  DATA_WIDTH/8  byte enables, active-low
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM controls, active-low
- sram_dq_o  out  DATA_WIDTH  write data to the top-level tristate
- sram_dq_oe  out  1  1 = drive the DQ pins
- sram_dq_i  in  DATA_WIDTH  data from the DQ pins

Behaviour:
- Reset (asynchronous, takes effect at any time including mid-access):
  - sram_ce_n, sram_oe_n, sram_we_n = 1; sram_be_n = all ones.
  - sram_addr = 0, sram_dq_o = 0, sram_dq_oe = 0.
  - All gnt and done = 0; rdata = 0.
  - State returns to IDLE; starvation counter = 0; any in-flight access is abandoned with no done.
- All outputs are registered.
- States are IDLE, READ, WRITE, DONE.
- IDLE:
  - At clock edge N, if any request is high, the arbiter picks a winner and latches its addr, we, wdata and be.
  - It asserts the winner's gnt during cycle N+1 only.
  - It enters READ or WRITE; the SRAM pins are driven from cycle N+1.
- READ:
  - ce_n = 0, oe_n = 0, dq_oe = 0 for ACCESS_CYCLES cycles.
  - sram_dq_i is captured into rdata at the final edge.
- WRITE:
  - ce_n = 0, we_n = 0, dq_oe = 1 for ACCESS_CYCLES cycles.
- DONE (one cycle):
  - ce_n, oe_n, we_n = 1.
  - After a write, dq_oe stays 1 and sram_dq_o stays unchanged, giving data hold after the rising edge of we_n; dq_oe returns to 0 on the next edge.
  - The winner's done is high this cycle.
  - Next state is IDLE.
- Latency: gnt in cycle N+1, done in cycle N+1+ACCESS_CYCLES; IDLE is re-entered at N+2+ACCESS_CYCLES.
  - The minimum request-sample-to-next-sample interval is ACCESS_CYCLES+2 cycles, so 4 at the default.
- Requests are only sampled in IDLE. A req still high during gnt or busy cycles is ignored; the requester drops req at the edge after it sees gnt.
- Arbitration:
  - Port 0 wins when both ports request, unless the starvation counter equals MAX_BURST, in which case port 1 wins.
  - The counter increments on each port-0 grant while p1_req is high, saturating at MAX_BURST.
  - The counter clears on a port-1 grant and on any IDLE sample where p1_req is low.
  - A single requester always wins immediately.
- sram_be_n = ~latched be for both reads and writes.
- The address is registered, so no wrap-around logic is required.

Decomposition:
- Package sram_arb_pkg holds:
  - the state enum typedef (IDLE, READ, WRITE, DONE);
  - a port-index typedef (PORT_VIDEO = 0, PORT_GEN = 1);
  - a command struct typedef (we, addr, wdata, be);
  - the default ACCESS_CYCLES and MAX_BURST constants.
- One sub-module, sram_arb_pick, is natural: the winner select plus the starvation counter. Inputs are the two reqs, a sample enable and reset; outputs are the winner index and valid.

Test Plan:
- Read, port 1 only: p1_req=1, p1_we=0, addr 20'h00010, sram_dq_i = 32'hDEADBEEF.
  - p1_gnt in cycle 1; ce_n=0 and oe_n=0 in cycles 1–2; p1_done plus rdata=32'hDEADBEEF in cycle 3; ce_n=1 in cycle 3.
- Write, port 0 only: addr 20'hFFFFF, wdata 32'h12345678, be 4'b0011.
  - sram_be_n=4'b1100; we_n=0 for 2 cycles; dq_oe=1 through the DONE cycle then 0; p0_done in cycle 3.
- Simultaneous requests: both reqs high.
  - Port 0 is granted first; port 1 is granted at the next IDLE sample, 4 cycles later.
- Starvation guard: MAX_BURST=4; p0_req and p1_req held continuously, each port re-requesting after its gnt.
  - Grant order is 0,0,0,0,1,0,0,0,0,1.
- Reset mid-write: assert reset during the first WRITE cycle.
  - Outputs return to reset values in the same cycle; no done; after release, a pending request is granted normally.
- ACCESS_CYCLES=1 back-to-back port-1 reads.
  - done every 3 cycles; rdata holds its value between done pulses.
